mux_select_scan_controller: RTL and testbench

//  Sequencer that drives the 4-bit select of the 16:1 switch-to-LED mux.

---
 rtl/mux_select_scan_controller.sv | 166 ++++++++++++++++
 tb/tb_mux_select_scan_controller.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_select_scan_controller.sv
// Mux select sequencer: debounced buttons drive MANUAL / SCAN_RUN / SCAN_HOLD modes.
// Optional `SKIP_ZERO_EN: dwell advances skip to the next index whose switch is on.
module mux_select_scan_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned DWELL_CYCLES    = 100_000_000
) (
  input  logic        clkFromBoard,
  input  logic        resetButtonActiveLow,
  input  logic        upBtn,
  input  logic        downBtn,
  input  logic        leftBtn,
  input  logic        rightBtn,
  input  logic [15:0] physicalSwitchInputs,
  output logic [3:0]  selectorLineForMUX,
  output logic        scanModeActive,
  output logic        scanPaused,
  output logic        selChangeStrobe
);

  localparam int unsigned DebW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned DwellW = $clog2(DWELL_CYCLES + 1);

  typedef enum logic [1:0] {MANUAL, SCAN_RUN, SCAN_HOLD} state_t;

  state_t            state, stateNext;
  logic [3:0]        sel, selNext, advSel;
  logic [DwellW-1:0] dwell, dwellNext;
  logic              strobe;

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rstSync;
  logic       rstN;

  always_ff @(posedge clkFromBoard or negedge resetButtonActiveLow) begin
    if (!resetButtonActiveLow) rstSync <= '0;
    else                       rstSync <= {rstSync[0], 1'b1};
  end

  assign rstN = rstSync[1];

  // Button index: 0 up, 1 down, 2 left, 3 right.
  logic [3:0]     rawBtn, sync1, sync2, debLevel, press;
  logic [DebW-1:0] debCnt [4];

  assign rawBtn = {rightBtn, leftBtn, downBtn, upBtn};

  always_ff @(posedge clkFromBoard or negedge rstN) begin
    if (!rstN) begin
      sync1    <= '0;
      sync2    <= '0;
      debLevel <= '0;
      press    <= '0;
      for (int unsigned i = 0; i < 4; i++) debCnt[i] <= '0;
    end else begin
      sync1 <= rawBtn;
      sync2 <= sync1;
      press <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] != debLevel[i]) begin
          if (debCnt[i] == DebW'(DEBOUNCE_CYCLES - 1)) begin
            debLevel[i] <= sync2[i];
            press[i]    <= sync2[i];
            debCnt[i]   <= '0;
          end else begin
            debCnt[i] <= debCnt[i] + DebW'(1);
          end
        end else begin
          debCnt[i] <= '0;
        end
      end
    end
  end

`ifdef SKIP_ZERO_EN
  function automatic logic [3:0] nextLitIndex(input logic [3:0] cur, input logic [15:0] sw);
    logic [3:0] res;
    logic [3:0] idx;
    logic       found;
    res   = cur + 4'd1;
    found = 1'b0;
    for (int unsigned i = 1; i < 16; i++) begin
      idx = cur + 4'(i);
      if (!found && sw[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    // Only the current input lit: stay put rather than stepping onto a dark one.
    if (!found && sw[cur]) res = cur;
    return res;
  endfunction

  assign advSel = nextLitIndex(sel, physicalSwitchInputs);
`else
  logic unusedSwitches;
  assign unusedSwitches = ^physicalSwitchInputs;
  assign advSel         = sel + 4'd1;
`endif

  logic stepUp, stepDown;

  always_comb begin
    stateNext = state;
    selNext   = sel;
    dwellNext = dwell;
    stepUp    = press[0] & ~press[1];
    stepDown  = press[1] & ~press[0];
    case (state)
      MANUAL: begin
        if (press[2]) begin
          stateNext = SCAN_RUN;
          dwellNext = '0;
        end else if (stepUp) begin
          selNext = sel + 4'd1;
        end else if (stepDown) begin
          selNext = sel - 4'd1;
        end
      end
      SCAN_RUN: begin
        if (press[2]) begin
          stateNext = MANUAL;
        end else if (press[3]) begin
          stateNext = SCAN_HOLD;
        end else if (dwell == DwellW'(DWELL_CYCLES - 1)) begin
          dwellNext = '0;
          selNext   = advSel;
        end else begin
          dwellNext = dwell + DwellW'(1);
        end
      end
      SCAN_HOLD: begin
        if (press[2]) begin
          stateNext = MANUAL;
        end else if (press[3]) begin
          stateNext = SCAN_RUN;
          dwellNext = '0;
        end else if (stepUp) begin
          selNext = sel + 4'd1;
        end else if (stepDown) begin
          selNext = sel - 4'd1;
        end
      end
      default: stateNext = MANUAL;
    endcase
  end

  always_ff @(posedge clkFromBoard or negedge rstN) begin
    if (!rstN) begin
      state  <= MANUAL;
      sel    <= '0;
      dwell  <= '0;
      strobe <= 1'b0;
    end else begin
      state  <= stateNext;
      sel    <= selNext;
      dwell  <= dwellNext;
      strobe <= (selNext != sel);
    end
  end

  assign selectorLineForMUX = sel;
  assign scanModeActive     = (state != MANUAL);
  assign scanPaused         = (state == SCAN_HOLD);
  assign selChangeStrobe    = strobe;

endmodule

// File: tb/tb_mux_select_scan_controller.sv
// Directed bench for mux_select_scan_controller (DEBOUNCE_CYCLES=4, DWELL_CYCLES=8).
// Define SKIP_ZERO_EN for both files to exercise the switch-skipping advance.
module tb_mux_select_scan_controller;

  logic        clk   = 1'b0;
  logic        rstN  = 1'b0;
  logic        up    = 1'b0;
  logic        down  = 1'b0;
  logic        left  = 1'b0;
  logic        right = 1'b0;
  logic [15:0] sw    = '0;
  logic [3:0]  sel;
  logic        scanAct, paused, strobe;

  int checks = 0;
  int errors = 0;

  mux_select_scan_controller #(
    .DEBOUNCE_CYCLES(4),
    .DWELL_CYCLES   (8)
  ) dut (
    .clkFromBoard        (clk),
    .resetButtonActiveLow(rstN),
    .upBtn               (up),
    .downBtn             (down),
    .leftBtn             (left),
    .rightBtn            (right),
    .physicalSwitchInputs(sw),
    .selectorLineForMUX  (sel),
    .scanModeActive      (scanAct),
    .scanPaused          (paused),
    .selChangeStrobe     (strobe)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyReset();
    rstN = 1'b0;
    tick(3);
    rstN = 1'b1;
    tick(4);
  endtask

  task automatic test_reset();
    tick(2);
    checks++;
    if ({sel, scanAct, paused, strobe} !== 7'b0) begin
      errors++;
      $display("FAIL resetState: sel=%0d act=%b paused=%b strobe=%b expected all 0", sel, scanAct, paused, strobe);
    end
    rstN = 1'b1;
    tick(4);
    left = 1'b1;
    tick(7);
    left = 1'b0;
    checks++;
    if ({scanAct, sel} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL resetEnterScan: act=%b sel=%0d expected act=1 sel=0", scanAct, sel);
    end
    tick(40);
    checks++;
    if ({scanAct, sel} !== {1'b1, 4'd5}) begin
      errors++;
      $display("FAIL resetScanToFive: act=%b sel=%0d expected act=1 sel=5", scanAct, sel);
    end
    #2 rstN = 1'b0;
    #1;
    checks++;
    if ({sel, scanAct, paused, strobe} !== 7'b0) begin
      errors++;
      $display("FAIL asyncReset: sel=%0d act=%b paused=%b strobe=%b expected all 0", sel, scanAct, paused, strobe);
    end
    tick(2);
    rstN = 1'b1;
    tick(4);
  endtask

  task automatic test_manual_step();
    up = 1'b1;
    tick(3);
    up = 1'b0;
    tick(10);
    checks++;
    if (sel !== 4'd0) begin
      errors++;
      $display("FAIL shortGlitch: sel=%0d expected 0", sel);
    end
    up = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      checks++;
      if (sel !== 4'd0) begin
        errors++;
        $display("FAIL upLatency edge %0d: sel=%0d expected 0", i, sel);
      end
    end
    tick(1);
    checks++;
    if ({sel, strobe} !== {4'd1, 1'b1}) begin
      errors++;
      $display("FAIL upStep: sel=%0d strobe=%b expected sel=1 strobe=1", sel, strobe);
    end
    tick(1);
    checks++;
    if ({sel, strobe} !== {4'd1, 1'b0}) begin
      errors++;
      $display("FAIL upStrobeWidth: sel=%0d strobe=%b expected sel=1 strobe=0", sel, strobe);
    end
    tick(12);
    up = 1'b0;
    tick(10);
    checks++;
    if (sel !== 4'd1) begin
      errors++;
      $display("FAIL upHeldNoRepeat: sel=%0d expected 1", sel);
    end
    down = 1'b1;
    tick(8);
    down = 1'b0;
    tick(8);
    checks++;
    if (sel !== 4'd0) begin
      errors++;
      $display("FAIL downToZero: sel=%0d expected 0", sel);
    end
    down = 1'b1;
    tick(8);
    down = 1'b0;
    tick(8);
    checks++;
    if (sel !== 4'd15) begin
      errors++;
      $display("FAIL downWrap: sel=%0d expected 15", sel);
    end
  endtask

  task automatic test_scan_run();
    left = 1'b1;
    tick(7);
    left = 1'b0;
    checks++;
    if ({scanAct, paused, sel} !== {1'b1, 1'b0, 4'd15}) begin
      errors++;
      $display("FAIL scanEnter: act=%b paused=%b sel=%0d expected 1 0 15", scanAct, paused, sel);
    end
    tick(8);
    checks++;
    if ({sel, strobe} !== {4'd0, 1'b1}) begin
      errors++;
      $display("FAIL scanWrap: sel=%0d strobe=%b expected sel=0 strobe=1", sel, strobe);
    end
    tick(8);
    checks++;
    if (sel !== 4'd1) begin
      errors++;
      $display("FAIL scanAdvance: sel=%0d expected 1", sel);
    end
    left = 1'b1;
    tick(7);
    left = 1'b0;
    checks++;
    if ({scanAct, sel} !== {1'b0, 4'd1}) begin
      errors++;
      $display("FAIL scanExit: act=%b sel=%0d expected act=0 sel=1", scanAct, sel);
    end
    tick(20);
    checks++;
    if ({scanAct, sel} !== {1'b0, 4'd1}) begin
      errors++;
      $display("FAIL manualFrozen: act=%b sel=%0d expected act=0 sel=1", scanAct, sel);
    end
  endtask

  task automatic test_scan_hold();
    logic moved;
    left = 1'b1;
    tick(7);
    left = 1'b0;
    right = 1'b1;
    tick(7);
    right = 1'b0;
    checks++;
    if ({scanAct, paused, sel} !== {1'b1, 1'b1, 4'd1}) begin
      errors++;
      $display("FAIL holdEnter: act=%b paused=%b sel=%0d expected 1 1 1", scanAct, paused, sel);
    end
    moved = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (sel !== 4'd1) moved = 1'b1;
    end
    checks++;
    if (moved !== 1'b0) begin
      errors++;
      $display("FAIL holdFrozen: moved=%b sel=%0d expected sel steady at 1", moved, sel);
    end
    up = 1'b1;
    tick(7);
    checks++;
    if ({sel, strobe} !== {4'd2, 1'b1}) begin
      errors++;
      $display("FAIL holdStep: sel=%0d strobe=%b expected sel=2 strobe=1", sel, strobe);
    end
    up = 1'b0;
    tick(10);
    right = 1'b1;
    tick(7);
    right = 1'b0;
    checks++;
    if ({scanAct, paused, sel} !== {1'b1, 1'b0, 4'd2}) begin
      errors++;
      $display("FAIL resume: act=%b paused=%b sel=%0d expected 1 0 2", scanAct, paused, sel);
    end
    tick(7);
    checks++;
    if (sel !== 4'd2) begin
      errors++;
      $display("FAIL resumeEarly: sel=%0d expected 2", sel);
    end
    tick(1);
    checks++;
    if ({sel, strobe} !== {4'd3, 1'b1}) begin
      errors++;
      $display("FAIL resumeAdvance: sel=%0d strobe=%b expected sel=3 strobe=1", sel, strobe);
    end
    left = 1'b1;
    tick(7);
    left = 1'b0;
    checks++;
    if ({scanAct, sel} !== {1'b0, 4'd3}) begin
      errors++;
      $display("FAIL holdTestExit: act=%b sel=%0d expected act=0 sel=3", scanAct, sel);
    end
    tick(10);
  endtask

  task automatic test_simultaneous();
    logic seen;
    up   = 1'b1;
    down = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (strobe) seen = 1'b1;
    end
    up   = 1'b0;
    down = 1'b0;
    tick(10);
    checks++;
    if ({sel, seen} !== {4'd3, 1'b0}) begin
      errors++;
      $display("FAIL upDownTogether: sel=%0d strobeSeen=%b expected sel=3 strobeSeen=0", sel, seen);
    end
    left = 1'b1;
    up   = 1'b1;
    tick(7);
    left = 1'b0;
    up   = 1'b0;
    checks++;
    if ({scanAct, sel, strobe} !== {1'b1, 4'd3, 1'b0}) begin
      errors++;
      $display("FAIL leftOverUp: act=%b sel=%0d strobe=%b expected 1 3 0", scanAct, sel, strobe);
    end
    tick(8);
    checks++;
    if (sel !== 4'd4) begin
      errors++;
      $display("FAIL leftOverUpAdvance: sel=%0d expected 4", sel);
    end
  endtask

`ifndef SKIP_ZERO_EN
  task automatic test_plain_advance();
    sw = 16'h0010;
    tick(8);
    checks++;
    if ({sel, strobe} !== {4'd5, 1'b1}) begin
      errors++;
      $display("FAIL plainAdvance: sel=%0d strobe=%b expected sel=5 strobe=1", sel, strobe);
    end
    sw = '0;
  endtask
`else
  task automatic test_skip_zero();
    logic [3:0] expSeq [4];
    logic       bad;
    applyReset();
    sw = 16'h0105;
    left = 1'b1;
    tick(7);
    left = 1'b0;
    expSeq = '{4'd2, 4'd8, 4'd0, 4'd2};
    for (int i = 0; i < 4; i++) begin
      tick(8);
      checks++;
      if ({sel, strobe} !== {expSeq[i], 1'b1}) begin
        errors++;
        $display("FAIL skipSeq[%0d]: sel=%0d strobe=%b expected sel=%0d strobe=1", i, sel, strobe, expSeq[i]);
      end
    end
    applyReset();
    sw = '0;
    left = 1'b1;
    tick(7);
    left = 1'b0;
    expSeq = '{4'd1, 4'd2, 4'd3, 4'd4};
    for (int i = 0; i < 4; i++) begin
      tick(8);
      checks++;
      if (sel !== expSeq[i]) begin
        errors++;
        $display("FAIL allZeroSeq[%0d]: sel=%0d expected %0d", i, sel, expSeq[i]);
      end
    end
    sw  = 16'h0010;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (sel !== 4'd4 || strobe !== 1'b0) bad = 1'b1;
    end
    checks++;
    if ({sel, bad} !== {4'd4, 1'b0}) begin
      errors++;
      $display("FAIL onlyCurrentLit: sel=%0d disturbed=%b expected sel=4 disturbed=0", sel, bad);
    end
    sw = '0;
  endtask
`endif

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_manual_step();
    test_scan_run();
    test_scan_hold();
    test_simultaneous();
`ifndef SKIP_ZERO_EN
    test_plain_advance();
`else
    test_skip_zero();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
